// File: rtl/perceptron_neuron_seq.sv
// rtl/perceptron_neuron_seq.sv - single-neuron perceptron with one time-shared multiplier
module perceptron_neuron_seq #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 20,
  parameter int OUT_W    = 8,
  parameter int SHIFT    = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            w_wr_en,
  input  logic [$clog2(N_INPUTS+1)-1:0]   w_wr_addr,
  input  logic [DATA_W-1:0]               w_wr_data,
  input  logic                            act_mode,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W-1:0]               x_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUT_W-1:0]                out_data,
  output logic                            busy
);

  localparam int AW     = $clog2(N_INPUTS + 1);
  localparam int IDX_W  = $clog2(N_INPUTS);
  localparam int PROD_W = 2 * DATA_W + 1;
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX  = ACC_W'((2 ** OUT_W) - 1);

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    FINISH = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [DATA_W-1:0] w_mem [N_INPUTS];
  logic signed [DATA_W-1:0] bias;
  logic signed [DATA_W-1:0] w_cur;
  logic signed [PROD_W-1:0] x_ext, w_ext, prod;
  logic signed [ACC_W-1:0]  acc, acc_base, acc_nxt, prod_ext, bias_ext, shifted;
  logic [IDX_W-1:0]         idx;
  logic [OUT_W-1:0]         act_val;
  logic                     accept;

  // X is zero-extended by one bit so an unsigned element times a signed weight stays exact
  assign w_cur    = w_mem[idx];
  assign x_ext    = {{(DATA_W + 1){1'b0}}, x_data};
  assign w_ext    = {{(DATA_W + 1){w_cur[DATA_W-1]}}, w_cur};
  assign prod     = x_ext * w_ext;
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign bias_ext = {{(ACC_W - DATA_W){bias[DATA_W-1]}}, bias};
  assign acc_base = (idx == '0) ? bias_ext : acc;
  assign acc_nxt  = acc_base + prod_ext;
  assign accept   = in_valid && in_ready;
  assign busy     = (idx != '0) || (state != ACCUM);

  // Activation: ReLU clamps the shifted sum to [0, 2^OUT_W-1]; step looks at the raw sum
  always_comb begin
    shifted = acc >>> SHIFT;
    act_val = '0;
    if (act_mode) begin
      if (shifted[ACC_W-1] || (shifted == '0)) begin
        act_val = '0;
      end else if (shifted > OUT_MAX) begin
        act_val = '1;
      end else begin
        act_val = shifted[OUT_W-1:0];
      end
    end else begin
      act_val = (!acc[ACC_W-1] && (acc != '0)) ? OUT_W'(1) : '0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and stream-side handshake
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && (idx == LAST_IDX)) begin
          state_nxt = FINISH;
        end
      end
      FINISH: state_nxt = HOLD;
      HOLD: begin
        if (out_ready) begin
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Weight and bias register file; out-of-range addresses fall through untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        w_mem[i] <= '0;
      end
      bias <= '0;
    end else if (w_wr_en) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        if (w_wr_addr == AW'(i)) begin
          w_mem[i] <= w_wr_data;
        end
      end
      if (w_wr_addr == AW'(N_INPUTS)) begin
        bias <= w_wr_data;
      end
    end
  end

  // Accumulate accepted elements, latch the activation in FINISH, release it on out_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept) begin
        acc <= acc_nxt;
        idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end
      if (state == FINISH) begin
        out_data  <= act_val;
        out_valid <= 1'b1;
      end
      if ((state == HOLD) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
